multicycle_seq: RTL and testbench
=================================

Name: multicycle_seq

Overview:
- Control sequencer for the multicycle RV32I-subset datapath.
- Generates per-cycle load enables for the datapath's n-bit registers: PC, IR, A/B, ALUOut and MDR.
- Generates the register-file write enable and the memory request/handshake.
- Sits between instruction memory/data memory and the register/ALU datapath. Also keeps a retired-instruction count and latches error status.

Parameters:
- TIMEOUT, 16, max cycles a memory request may wait for mem_ready; 0 disables the timeout.
- WAIT_W, 8, width of the wait counter; must satisfy 2^WAIT_W > TIMEOUT.
- CNT_W, 32, width of the instret counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- run  in  1  1 = keep executing; sampled only at instruction boundaries.
- opcode  in  7  IR[6:0] from the datapath.
- branch_taken  in  1  branch comparison result; sampled only in EXEC of a BRANCH.
- mem_ready  in  1  memory completes the current request this cycle.
- pc_load, ir_load, ab_load, alu_load, mdr_load  out  1 each  register load enables.
- pc_src  out  1  0 = PC+4, 1 = ALUOut.
- addr_sel  out  1  0 = PC, 1 = ALUOut.
- wb_sel  out  2  0 = ALUOut, 1 = MDR, 2 = link (current PC).
- rf_we  out  1  register-file write enable.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write.
- state  out  3  current state.
- instret  out  CNT_W  retired-instruction count.
- err  out  2  0 = none, 1 = illegal opcode, 2 = memory timeout.

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
- Registered: state, wait_cnt, instret, err.
- Combinational from current state and inputs: all enables, selects and mem_* outputs. Every enable is 0 unless listed below for a state.
- Reset (asserted asynchronously):
  - state=IDLE; instret=0; err=0; wait_cnt=0.
  - All combinational outputs are 0 in IDLE, so enables drop in the same instant reset asserts.
  - Reset mid-instruction abandons the instruction; it is not counted.
- "next" means FETCH if run=1, else IDLE.
- IDLE: run=1 -> FETCH.
- FETCH:
  - mem_req=1, addr_sel=0, mem_we=0.
  - mem_ready=1: ir_load=1, pc_load=1, pc_src=0 -> DECODE.
  - mem_ready=0: stay in FETCH.
- DECODE:
  - ab_load=1.
  - Legal opcode -> EXEC. Legal set: 0110011 R, 0010011 I, 0000011 LOAD, 0100011 STORE, 1100011 BRANCH, 1101111 JAL.
  - Any other opcode -> HALT, err=1.
- EXEC:
  - alu_load=1.
  - R/I -> WB.
  - LOAD/STORE -> MEM.
  - JAL -> WB.
  - BRANCH: if branch_taken, pc_load=1 and pc_src=1; instret+1; -> next.
- MEM:
  - mem_req=1, addr_sel=1, mem_we=1 for STORE only.
  - LOAD with mem_ready=1: mdr_load=1 -> WB.
  - STORE with mem_ready=1: instret+1 -> next.
  - mem_ready=0: stay in MEM.
- WB:
  - rf_we=1; instret+1; -> next.
  - wb_sel: 1 for LOAD, 2 for JAL, 0 otherwise.
  - JAL also: pc_load=1, pc_src=1.
- HALT: all enables 0; stays in HALT until reset; err holds its value.
- Opcode is held stable by IR from DECODE onward; the sequencer may decode it in any state after DECODE.
- Timeout:
  - wait_cnt clears to 0 on entry to FETCH or MEM.
  - Each FETCH/MEM cycle with mem_ready=0: if TIMEOUT≠0 and wait_cnt==TIMEOUT-1 -> HALT, err=2; else wait_cnt+1.
  - mem_ready=1 in the same cycle has priority over timeout.
- Latency with zero-wait memory: R/I 4 cycles, LOAD 5, STORE 4, BRANCH 3, JAL 4. Each wait cycle adds 1.
- run=0 mid-instruction: the instruction completes, then the block enters IDLE.
- instret wraps modulo 2^CNT_W.

Test Plan:
- Reset low, then run=1, opcode 0110011, mem_ready=1 always -> states 1,2,3,5,1. ir_load and pc_load high in FETCH cycle; rf_we=1 with wb_sel=0 in WB; instret=1 after 4 cycles.
- LOAD (0000011), mem_ready low for 2 MEM cycles then high -> mem_req=1 and addr_sel=1 for 3 MEM cycles; mdr_load=1 on the third; WB has wb_sel=1; total 7 cycles.
- BRANCH with branch_taken=1, then run=0 -> EXEC has pc_load=1 and pc_src=1; state returns to IDLE; instret=1. Repeat with branch_taken=0 -> pc_load=0 in EXEC.
- TIMEOUT=4, mem_ready held 0 in FETCH -> HALT on the 5th cycle (after 4 waits), err=2. Separate run: mem_ready=1 on the 4th FETCH cycle -> DECODE, err=0.
- Opcode 1111111 -> HALT after DECODE, err=1; all enables 0 for 10 further cycles.
- Assert rst low during MEM of a STORE -> state=0 and mem_req=0 immediately (asynchronously); instret unchanged from 0; err=0.

Source files
------------

// File: rtl/multicycle_seq.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_seq
// Purpose  : Control sequencer for a multicycle RV32I-subset datapath.
//            Walks each instruction through FETCH / DECODE / EXEC / MEM / WB.
//            In each cycle it raises the register load enables, the
//            register-file write enable and the memory request/handshake.
//            It also keeps a retired-instruction counter and latches error
//            status (illegal opcode, memory timeout) in a sticky HALT state.
// Ports    :
//   clk          in   single clock, rising edge
//   rst          in   asynchronous, active-low reset
//   run          in   1 = keep executing (sampled at instruction boundaries)
//   opcode[6:0]  in   IR[6:0]; stable from DECODE onward
//   branch_taken in   branch compare result, used in EXEC of a BRANCH
//   mem_ready    in   memory completes the current request this cycle
//   pc_load, ir_load, ab_load, alu_load, mdr_load  out  register loads
//   pc_src       out  0 = PC+4, 1 = ALUOut
//   addr_sel     out  0 = PC, 1 = ALUOut
//   wb_sel[1:0]  out  0 = ALUOut, 1 = MDR, 2 = link (PC)
//   rf_we        out  register-file write enable
//   mem_req      out  memory request
//   mem_we       out  memory write
//   state[2:0]   out  current state (IDLE=0 .. HALT=6)
//   instret      out  retired-instruction count (wraps)
//   err[1:0]     out  0 = none, 1 = illegal opcode, 2 = memory timeout
// Revision : 1.0  initial release
// ============================================================================
module multicycle_seq #(
  parameter int TIMEOUT = 16,  // max wait cycles per memory request, 0 = off
  parameter int WAIT_W  = 8,   // wait counter width, 2**WAIT_W > TIMEOUT
  parameter int CNT_W   = 32   // instret width
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [6:0]       opcode,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             pc_load,
  output logic             ir_load,
  output logic             ab_load,
  output logic             alu_load,
  output logic             mdr_load,
  output logic             pc_src,
  output logic             addr_sel,
  output logic [1:0]       wb_sel,
  output logic             rf_we,
  output logic             mem_req,
  output logic             mem_we,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret,
  output logic [1:0]       err
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [6:0] c_OP_R      = 7'b0110011;
  localparam logic [6:0] c_OP_I      = 7'b0010011;
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;

  localparam logic [1:0] c_WB_ALU  = 2'd0;
  localparam logic [1:0] c_WB_MDR  = 2'd1;
  localparam logic [1:0] c_WB_LINK = 2'd2;

  localparam logic [1:0] c_ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] c_ERR_TIMEOUT = 2'd2;

  // Last wait count that is still tolerated; the next not-ready cycle halts.
  localparam int                c_WAIT_LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [WAIT_W-1:0] c_WAIT_LAST   = WAIT_W'(c_WAIT_LAST_I);
  localparam bit                c_TIMEOUT_EN  = (TIMEOUT != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  // --------------------------------------------------------------------------
  // Registers and wires
  // --------------------------------------------------------------------------
  state_t              r_state;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic [CNT_W-1:0]    r_instret;
  logic [1:0]          r_err;

  state_t              w_next;
  state_t              w_after;      // where to go once an instruction retires
  logic                w_retire;
  logic                w_wait_inc;   // stay in FETCH/MEM and count one wait
  logic                w_set_illegal;
  logic                w_set_timeout;
  logic                w_wait_expired;

  logic                w_is_r_i;
  logic                w_is_load;
  logic                w_is_store;
  logic                w_is_branch;
  logic                w_is_jal;
  logic                w_legal;

  // --------------------------------------------------------------------------
  // Opcode decode. IR holds the opcode steady from DECODE onward, so the
  // class can be decoded live in every later state instead of being latched.
  // --------------------------------------------------------------------------
  assign w_is_r_i    = (opcode == c_OP_R) || (opcode == c_OP_I);
  assign w_is_load   = (opcode == c_OP_LOAD);
  assign w_is_store  = (opcode == c_OP_STORE);
  assign w_is_branch = (opcode == c_OP_BRANCH);
  assign w_is_jal    = (opcode == c_OP_JAL);
  assign w_legal     = w_is_r_i || w_is_load || w_is_store ||
                       w_is_branch || w_is_jal;

  assign w_after        = run ? S_FETCH : S_IDLE;
  assign w_wait_expired = c_TIMEOUT_EN && (r_wait_cnt == c_WAIT_LAST);

  // --------------------------------------------------------------------------
  // Next-state and output logic. All outputs default to 0 so that IDLE (and
  // therefore reset) drives every enable low combinationally.
  // --------------------------------------------------------------------------
  always_comb begin
    pc_load       = 1'b0;
    ir_load       = 1'b0;
    ab_load       = 1'b0;
    alu_load      = 1'b0;
    mdr_load      = 1'b0;
    pc_src        = 1'b0;
    addr_sel      = 1'b0;
    wb_sel        = c_WB_ALU;
    rf_we         = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    w_next        = r_state;
    w_retire      = 1'b0;
    w_wait_inc    = 1'b0;
    w_set_illegal = 1'b0;
    w_set_timeout = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (run) begin
          w_next = S_FETCH;
        end
      end

      S_FETCH: begin
        mem_req = 1'b1;
        // mem_ready wins over an expiring wait count in the same cycle.
        if (mem_ready) begin
          ir_load = 1'b1;
          pc_load = 1'b1;
          w_next  = S_DECODE;
        end else if (w_wait_expired) begin
          w_set_timeout = 1'b1;
          w_next        = S_HALT;
        end else begin
          w_wait_inc = 1'b1;
        end
      end

      S_DECODE: begin
        ab_load = 1'b1;
        if (w_legal) begin
          w_next = S_EXEC;
        end else begin
          w_set_illegal = 1'b1;
          w_next        = S_HALT;
        end
      end

      S_EXEC: begin
        alu_load = 1'b1;
        if (w_is_load || w_is_store) begin
          w_next = S_MEM;
        end else if (w_is_branch) begin
          // Branch resolves here: the target is already in ALUOut.
          if (branch_taken) begin
            pc_load = 1'b1;
            pc_src  = 1'b1;
          end
          w_retire = 1'b1;
          w_next   = w_after;
        end else if (w_is_r_i || w_is_jal) begin
          w_next = S_WB;
        end else begin
          // Unreachable while IR holds a decoded-legal opcode.
          w_set_illegal = 1'b1;
          w_next        = S_HALT;
        end
      end

      S_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = w_is_store;
        if (mem_ready) begin
          if (w_is_store) begin
            w_retire = 1'b1;
            w_next   = w_after;
          end else begin
            mdr_load = 1'b1;
            w_next   = S_WB;
          end
        end else if (w_wait_expired) begin
          w_set_timeout = 1'b1;
          w_next        = S_HALT;
        end else begin
          w_wait_inc = 1'b1;
        end
      end

      S_WB: begin
        rf_we    = 1'b1;
        w_retire = 1'b1;
        w_next   = w_after;
        if (w_is_load) begin
          wb_sel = c_WB_MDR;
        end else if (w_is_jal) begin
          wb_sel  = c_WB_LINK;
          pc_load = 1'b1;
          pc_src  = 1'b1;
        end
      end

      S_HALT: begin
        w_next = S_HALT;
      end

      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State register, wait counter, retired count and sticky error.
  // The wait counter only survives while sitting in FETCH/MEM without
  // mem_ready; any other transition (including entry to FETCH/MEM) clears it.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
      r_instret  <= '0;
      r_err      <= 2'd0;
    end else begin
      r_state <= w_next;

      if (w_wait_inc) begin
        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
      end else begin
        r_wait_cnt <= '0;
      end

      if (w_retire) begin
        r_instret <= r_instret + CNT_W'(1);
      end

      if (w_set_illegal) begin
        r_err <= c_ERR_ILLEGAL;
      end else if (w_set_timeout) begin
        r_err <= c_ERR_TIMEOUT;
      end
    end
  end

  assign state   = r_state;
  assign instret = r_instret;
  assign err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_seq
// Purpose  : Self-checking bench for multicycle_seq. A directed vector table,
//            hand-written corner sequences, then randomized instruction
//            streams whose expected per-cycle behaviour is expanded from the
//            instruction-level rules (cycle list per instruction class).
// Revision : 1.0  initial release
// ============================================================================
module tb_multicycle_seq;

  localparam int TIMEOUT = 4;
  localparam int WAIT_W  = 8;
  localparam int CNT_W   = 32;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BAD    = 7'b1111111;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2,
                         ST_EXEC = 3'd3, ST_MEM = 3'd4, ST_WB = 3'd5,
                         ST_HALT = 3'd6;

  // Control vector field order:
  //   pc_load ir_load ab_load alu_load mdr_load pc_src addr_sel wb_sel[1:0]
  //   rf_we mem_req mem_we
  localparam logic [11:0] K_NONE       = 12'b0_0_0_0_0_0_0_00_0_0_0;
  localparam logic [11:0] K_FETCH_WAIT = 12'b0_0_0_0_0_0_0_00_0_1_0;
  localparam logic [11:0] K_FETCH_RDY  = 12'b1_1_0_0_0_0_0_00_0_1_0;
  localparam logic [11:0] K_DECODE     = 12'b0_0_1_0_0_0_0_00_0_0_0;
  localparam logic [11:0] K_EXEC       = 12'b0_0_0_1_0_0_0_00_0_0_0;
  localparam logic [11:0] K_EXEC_TAKEN = 12'b1_0_0_1_0_1_0_00_0_0_0;
  localparam logic [11:0] K_MEM_LD     = 12'b0_0_0_0_0_0_1_00_0_1_0;
  localparam logic [11:0] K_MEM_LD_RDY = 12'b0_0_0_0_1_0_1_00_0_1_0;
  localparam logic [11:0] K_MEM_ST     = 12'b0_0_0_0_0_0_1_00_0_1_1;
  localparam logic [11:0] K_WB         = 12'b0_0_0_0_0_0_0_00_1_0_0;
  localparam logic [11:0] K_WB_LD      = 12'b0_0_0_0_0_0_0_01_1_0_0;
  localparam logic [11:0] K_WB_JAL     = 12'b1_0_0_0_0_1_0_10_1_0_0;

  logic             clk = 1'b0;
  logic             rst;
  logic             run;
  logic [6:0]       opcode;
  logic             branch_taken;
  logic             mem_ready;
  logic             pc_load, ir_load, ab_load, alu_load, mdr_load;
  logic             pc_src, addr_sel, rf_we, mem_req, mem_we;
  logic [1:0]       wb_sel;
  logic [2:0]       state;
  logic [CNT_W-1:0] instret;
  logic [1:0]       err;
  logic [11:0]      ctl;

  assign ctl = {pc_load, ir_load, ab_load, alu_load, mdr_load, pc_src,
                addr_sel, wb_sel, rf_we, mem_req, mem_we};

  multicycle_seq #(.TIMEOUT(TIMEOUT), .WAIT_W(WAIT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode),
    .branch_taken(branch_taken), .mem_ready(mem_ready),
    .pc_load(pc_load), .ir_load(ir_load), .ab_load(ab_load),
    .alu_load(alu_load), .mdr_load(mdr_load), .pc_src(pc_src),
    .addr_sel(addr_sel), .wb_sel(wb_sel), .rf_we(rf_we),
    .mem_req(mem_req), .mem_we(mem_we), .state(state),
    .instret(instret), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0]  op;
    logic        run;
    logic        rdy;
    logic        bt;
    logic [2:0]  st;
    logic [11:0] ctl;
  } rec_t;

  int          checks   = 0;
  int          failures = 0;
  rec_t        tbl [13];
  rec_t        q [$];
  logic        m_halt;
  logic [1:0]  m_halt_err;
  logic [31:0] exp_instret;

  function automatic rec_t mkrec(input logic [6:0] op, input logic rn,
                                 input logic rdy, input logic bt,
                                 input logic [2:0] st, input logic [11:0] k);
    rec_t r;
    r.op = op; r.run = rn; r.rdy = rdy; r.bt = bt; r.st = st; r.ctl = k;
    return r;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic legal(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called just after a rising edge: drive, check at the falling edge,
  // then advance through the next rising edge.
  task automatic apply(input rec_t r, input string tag);
    opcode = r.op; run = r.run; mem_ready = r.rdy; branch_taken = r.bt;
    @(negedge clk);
    check({tag, " state"}, 32'(state), 32'(r.st));
    check({tag, " ctl"}, 32'(ctl), 32'(r.ctl));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    check("reset state", 32'(state), 32'(ST_IDLE));
    check("reset ctl", 32'(ctl), 32'(K_NONE));
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset instret", instret, 32'd0);
    check("reset err", 32'(err), 32'd0);
    rst = 1'b1;
  endtask

  // Expand one instruction (starting in FETCH) into its expected cycles.
  // fw/mw = number of not-ready cycles before the fetch / data access.
  task automatic build_instr(input logic [6:0] op, input logic bt,
                             input int fw, input int mw, input logic fin);
    logic [11:0] mw_k;
    m_halt = 1'b0; m_halt_err = 2'd0;
    for (int i = 0; i < fw && i < TIMEOUT; i++)
      q.push_back(mkrec(op, rb(), 1'b0, rb(), ST_FETCH, K_FETCH_WAIT));
    if (fw >= TIMEOUT) begin m_halt = 1'b1; m_halt_err = 2'd2; return; end
    q.push_back(mkrec(op, rb(), 1'b1, rb(), ST_FETCH, K_FETCH_RDY));
    q.push_back(mkrec(op, rb(), rb(), rb(), ST_DECODE, K_DECODE));
    if (!legal(op)) begin m_halt = 1'b1; m_halt_err = 2'd1; return; end
    case (op)
      OP_BRANCH:
        q.push_back(mkrec(op, fin, rb(), bt, ST_EXEC, bt ? K_EXEC_TAKEN : K_EXEC));
      OP_LOAD, OP_STORE: begin
        mw_k = (op == OP_STORE) ? K_MEM_ST : K_MEM_LD;
        q.push_back(mkrec(op, rb(), rb(), rb(), ST_EXEC, K_EXEC));
        for (int i = 0; i < mw && i < TIMEOUT; i++)
          q.push_back(mkrec(op, rb(), 1'b0, rb(), ST_MEM, mw_k));
        if (mw >= TIMEOUT) begin m_halt = 1'b1; m_halt_err = 2'd2; return; end
        if (op == OP_STORE) begin
          q.push_back(mkrec(op, fin, 1'b1, rb(), ST_MEM, K_MEM_ST));
        end else begin
          q.push_back(mkrec(op, rb(), 1'b1, rb(), ST_MEM, K_MEM_LD_RDY));
          q.push_back(mkrec(op, fin, rb(), rb(), ST_WB, K_WB_LD));
        end
      end
      OP_JAL: begin
        q.push_back(mkrec(op, rb(), rb(), rb(), ST_EXEC, K_EXEC));
        q.push_back(mkrec(op, fin, rb(), rb(), ST_WB, K_WB_JAL));
      end
      default: begin
        q.push_back(mkrec(op, rb(), rb(), rb(), ST_EXEC, K_EXEC));
        q.push_back(mkrec(op, fin, rb(), rb(), ST_WB, K_WB));
      end
    endcase
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] op;
    logic       fin, in_idle;
    int         fw, mw, sel;

    // R-type then LOAD with two data wait cycles.
    tbl[0]  = mkrec(OP_R,    1, 1, 0, ST_IDLE,   K_NONE);
    tbl[1]  = mkrec(OP_R,    1, 1, 0, ST_FETCH,  K_FETCH_RDY);
    tbl[2]  = mkrec(OP_R,    1, 1, 0, ST_DECODE, K_DECODE);
    tbl[3]  = mkrec(OP_R,    1, 1, 0, ST_EXEC,   K_EXEC);
    tbl[4]  = mkrec(OP_R,    1, 1, 0, ST_WB,     K_WB);
    tbl[5]  = mkrec(OP_LOAD, 1, 1, 0, ST_FETCH,  K_FETCH_RDY);
    tbl[6]  = mkrec(OP_LOAD, 1, 1, 0, ST_DECODE, K_DECODE);
    tbl[7]  = mkrec(OP_LOAD, 1, 1, 0, ST_EXEC,   K_EXEC);
    tbl[8]  = mkrec(OP_LOAD, 1, 0, 0, ST_MEM,    K_MEM_LD);
    tbl[9]  = mkrec(OP_LOAD, 1, 0, 0, ST_MEM,    K_MEM_LD);
    tbl[10] = mkrec(OP_LOAD, 1, 1, 0, ST_MEM,    K_MEM_LD_RDY);
    tbl[11] = mkrec(OP_LOAD, 0, 1, 0, ST_WB,     K_WB_LD);
    tbl[12] = mkrec(OP_LOAD, 0, 1, 0, ST_IDLE,   K_NONE);

    run = 0; opcode = '0; mem_ready = 0; branch_taken = 0;
    do_reset();

    for (int i = 0; i < 13; i++) begin
      if (i == 5) check("R instret", instret, 32'd1);
      apply(tbl[i], $sformatf("tbl[%0d]", i));
    end
    check("LOAD instret", instret, 32'd2);

    // BRANCH taken then not taken, each with run=0 at the boundary.
    do_reset();
    apply(mkrec(OP_BRANCH, 1, 1, 0, ST_IDLE,   K_NONE),       "br1 idle");
    apply(mkrec(OP_BRANCH, 0, 1, 0, ST_FETCH,  K_FETCH_RDY),  "br1 fetch");
    apply(mkrec(OP_BRANCH, 0, 1, 0, ST_DECODE, K_DECODE),     "br1 decode");
    apply(mkrec(OP_BRANCH, 0, 1, 1, ST_EXEC,   K_EXEC_TAKEN), "br1 exec");
    apply(mkrec(OP_BRANCH, 0, 1, 1, ST_IDLE,   K_NONE),       "br1 idle2");
    check("br taken instret", instret, 32'd1);
    apply(mkrec(OP_BRANCH, 1, 1, 0, ST_IDLE,   K_NONE),       "br0 idle");
    apply(mkrec(OP_BRANCH, 1, 1, 0, ST_FETCH,  K_FETCH_RDY),  "br0 fetch");
    apply(mkrec(OP_BRANCH, 1, 1, 0, ST_DECODE, K_DECODE),     "br0 decode");
    apply(mkrec(OP_BRANCH, 0, 1, 0, ST_EXEC,   K_EXEC),       "br0 exec");
    apply(mkrec(OP_BRANCH, 0, 1, 0, ST_IDLE,   K_NONE),       "br0 idle2");
    check("br not-taken instret", instret, 32'd2);

    // Fetch timeout after TIMEOUT not-ready cycles.
    do_reset();
    apply(mkrec(OP_R, 1, 0, 0, ST_IDLE, K_NONE), "to idle");
    for (int i = 0; i < 4; i++)
      apply(mkrec(OP_R, 1, 0, 0, ST_FETCH, K_FETCH_WAIT), $sformatf("to wait%0d", i));
    apply(mkrec(OP_R, 1, 1, 0, ST_HALT, K_NONE), "to halt");
    check("timeout err", 32'(err), 32'd2);

    // Ready on the last tolerated cycle wins over the timeout.
    do_reset();
    apply(mkrec(OP_R, 1, 0, 0, ST_IDLE, K_NONE), "nto idle");
    for (int i = 0; i < 3; i++)
      apply(mkrec(OP_R, 1, 0, 0, ST_FETCH, K_FETCH_WAIT), $sformatf("nto wait%0d", i));
    apply(mkrec(OP_R, 1, 1, 0, ST_FETCH,  K_FETCH_RDY), "nto fetch");
    apply(mkrec(OP_R, 1, 0, 0, ST_DECODE, K_DECODE),    "nto decode");
    check("no-timeout err", 32'(err), 32'd0);
    apply(mkrec(OP_R, 1, 0, 0, ST_EXEC, K_EXEC), "nto exec");
    apply(mkrec(OP_R, 0, 0, 0, ST_WB,   K_WB),   "nto wb");
    apply(mkrec(OP_R, 0, 0, 0, ST_IDLE, K_NONE), "nto idle2");
    check("no-timeout instret", instret, 32'd1);

    // Illegal opcode halts after DECODE and stays put.
    do_reset();
    apply(mkrec(OP_BAD, 1, 1, 0, ST_IDLE,   K_NONE),      "ill idle");
    apply(mkrec(OP_BAD, 1, 1, 0, ST_FETCH,  K_FETCH_RDY), "ill fetch");
    apply(mkrec(OP_BAD, 1, 1, 0, ST_DECODE, K_DECODE),    "ill decode");
    for (int i = 0; i < 10; i++)
      apply(mkrec(OP_BAD, rb(), rb(), rb(), ST_HALT, K_NONE), $sformatf("ill halt%0d", i));
    check("illegal err", 32'(err), 32'd1);
    check("illegal instret", instret, 32'd0);

    // Asynchronous reset in the middle of a STORE access.
    do_reset();
    apply(mkrec(OP_STORE, 1, 1, 0, ST_IDLE,   K_NONE),      "rs idle");
    apply(mkrec(OP_STORE, 1, 1, 0, ST_FETCH,  K_FETCH_RDY), "rs fetch");
    apply(mkrec(OP_STORE, 1, 1, 0, ST_DECODE, K_DECODE),    "rs decode");
    apply(mkrec(OP_STORE, 1, 1, 0, ST_EXEC,   K_EXEC),      "rs exec");
    opcode = OP_STORE; run = 1; mem_ready = 0;
    @(negedge clk);
    check("rs mem state", 32'(state), 32'(ST_MEM));
    check("rs mem ctl", 32'(ctl), 32'(K_MEM_ST));
    #1 rst = 1'b0;
    #1;
    check("rs async state", 32'(state), 32'(ST_IDLE));
    check("rs async mem_req", 32'(mem_req), 32'd0);
    check("rs async ctl", 32'(ctl), 32'(K_NONE));
    check("rs instret", instret, 32'd0);
    check("rs err", 32'(err), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    // Randomized instruction stream against the instruction-level model.
    do_reset();
    in_idle = 1'b1;
    exp_instret = 0;
    for (int n = 0; n < 250; n++) begin
      sel = $urandom_range(0, 12);
      case (sel)
        0, 1:    op = OP_R;
        2, 3:    op = OP_I;
        4, 5:    op = OP_LOAD;
        6, 7:    op = OP_STORE;
        8, 9:    op = OP_BRANCH;
        10, 11:  op = OP_JAL;
        default: begin
          op = 7'($urandom);
          while (legal(op)) op = 7'($urandom);
        end
      endcase
      fw  = ($urandom_range(0, 19) == 0) ? $urandom_range(4, 6) : $urandom_range(0, 3);
      mw  = ($urandom_range(0, 19) == 0) ? $urandom_range(4, 6) : $urandom_range(0, 3);
      fin = ($urandom_range(0, 3) != 0);
      q.delete();
      if (in_idle) begin
        sel = $urandom_range(0, 2);
        for (int i = 0; i < sel; i++)
          q.push_back(mkrec(op, 1'b0, rb(), rb(), ST_IDLE, K_NONE));
        q.push_back(mkrec(op, 1'b1, rb(), rb(), ST_IDLE, K_NONE));
      end
      build_instr(op, rb(), fw, mw, fin);
      if (m_halt)
        for (int i = 0; i < 3; i++)
          q.push_back(mkrec(op, rb(), rb(), rb(), ST_HALT, K_NONE));
      foreach (q[i]) apply(q[i], $sformatf("rnd%0d op=%b c%0d", n, op, i));
      check($sformatf("rnd%0d instret", n), instret, exp_instret + (m_halt ? 0 : 1));
      if (m_halt) begin
        check($sformatf("rnd%0d err", n), 32'(err), 32'(m_halt_err));
        do_reset();
        exp_instret = 0;
        in_idle = 1'b1;
      end else begin
        check($sformatf("rnd%0d err", n), 32'(err), 32'd0);
        exp_instret = exp_instret + 1;
        in_idle = !fin;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
